// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S/TDM receiver.
//   i2s_state_t       : receiver framing state (SYNC, SKIP, CAPT)
//   I2S_MAX_SLOT_W    : widest legal slot (and sample) in bit clocks
//   I2S_MAX_CH        : most channels per frame
//   I2S_MIN_SAMPLE_W  : narrowest legal sample
//   i2s_exp_ws()      : word-select level expected while sampling frame position pos
package i2s_pkg;

  typedef enum logic [1:0] {
    SYNC,
    SKIP,
    CAPT
  } i2s_state_t;

  localparam int unsigned I2S_MAX_SLOT_W   = 32;
  localparam int unsigned I2S_MAX_CH       = 8;
  localparam int unsigned I2S_MIN_SAMPLE_W = 8;

  // ws announces the half of the frame that the *next* bit belongs to, so the level seen
  // with bit pos is the half of pos+1.
  function automatic logic i2s_exp_ws(input int unsigned pos, input int unsigned frame_len);
    return ((pos + 1) % frame_len) >= (frame_len / 2);
  endfunction

endpackage

// File: rtl/i2s_sync_edge.sv
// Three-flop synchroniser with edge detection for one asynchronous input.
//   clk_i   : sampling clock
//   rst_ni  : asynchronous active-low reset, clears all flops
//   async_i : asynchronous input
//   sync_o  : input after two flops
//   rise_o  : one-cycle pulse, sync_o went 0->1
//   fall_o  : one-cycle pulse, sync_o went 1->0
module i2s_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], async_i};
    end
  end

  assign sync_o = sync_q[1];
  assign rise_o = sync_q[1] & ~sync_q[2];
  assign fall_o = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/i2s_rx_tdm.sv
// I2S/TDM serial-audio receiver. Recovers NUM_CH samples of SAMPLE_W bits (MSB first) from
// SLOT_W-bit slots and presents each complete frame in parallel.
//   clk      : system clock (>= 8x I2S_sclk)
//   rst_n    : asynchronous active-low reset
//   I2S_sclk : asynchronous serial bit clock, data sampled on its rise
//   I2S_ws   : asynchronous word select, low for first half of frame, high for second
//   I2S_data : asynchronous serial data
//   en       : receiver enable; low forces resynchronisation
//   smpl_out : last complete frame, channel c at [c*SAMPLE_W +: SAMPLE_W]
//   vld      : one-clk pulse when smpl_out updates
//   frm_err  : one-clk pulse on a word-select framing error
module i2s_rx_tdm
  import i2s_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 24,
  parameter int unsigned SLOT_W   = 32,
  parameter int unsigned NUM_CH   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       I2S_sclk,
  input  logic                       I2S_ws,
  input  logic                       I2S_data,
  input  logic                       en,
  output logic [NUM_CH*SAMPLE_W-1:0] smpl_out,
  output logic                       vld,
  output logic                       frm_err
);

  localparam int unsigned BitW     = $clog2(SLOT_W);
  localparam int unsigned ChW      = $clog2(NUM_CH);
  localparam int unsigned FrameLen = NUM_CH * SLOT_W;

  // Parameter legality
  if (SAMPLE_W < I2S_MIN_SAMPLE_W || SAMPLE_W > I2S_MAX_SLOT_W) begin : g_bad_sample_w
    $error("i2s_rx_tdm: SAMPLE_W must lie in 8..32");
  end
  if (SLOT_W < SAMPLE_W || SLOT_W > I2S_MAX_SLOT_W) begin : g_bad_slot_w
    $error("i2s_rx_tdm: SLOT_W must lie in SAMPLE_W..32");
  end
  if (NUM_CH < 2 || NUM_CH > I2S_MAX_CH || (NUM_CH % 2) != 0) begin : g_bad_num_ch
    $error("i2s_rx_tdm: NUM_CH must be even and lie in 2..8");
  end

  // ---------------------------------------------------------------------------------------
  // Synchronisers. Data is taken from the same flop depth as the sclk/ws sync outputs so a
  // bit and its word-select level are seen together with sclk_rise.
  // ---------------------------------------------------------------------------------------
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic ws_s, ws_rise, ws_fall;
  logic [1:0] data_q;
  logic data_s;

  i2s_sync_edge u_sync_sclk (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .async_i (I2S_sclk),
    .sync_o  (sclk_lvl),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  i2s_sync_edge u_sync_ws (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .async_i (I2S_ws),
    .sync_o  (ws_s),
    .rise_o  (ws_rise),
    .fall_o  (ws_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= {data_q[0], I2S_data};
    end
  end

  assign data_s = data_q[1];

  logic unused_sync;
  assign unused_sync = ^{sclk_lvl, sclk_fall, ws_rise};

  // ---------------------------------------------------------------------------------------
  // Framing FSM, counters and working registers
  // ---------------------------------------------------------------------------------------
  i2s_state_t                       state_q, state_d;
  logic [BitW-1:0]                  bit_q, bit_d;
  logic [ChW-1:0]                   ch_q, ch_d;
  logic [NUM_CH-1:0][SAMPLE_W-1:0]  wrk_q, wrk_d;
  logic [NUM_CH*SAMPLE_W-1:0]       smpl_q, smpl_d;
  logic                             vld_q, vld_d;
  logic                             err_q, err_d;
  logic [31:0]                      pos;

  assign pos = 32'(ch_q) * SLOT_W + 32'(bit_q);

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    ch_d    = ch_q;
    wrk_d   = wrk_q;
    smpl_d  = smpl_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;

    if (!en) begin
      state_d = SYNC;
      bit_d   = '0;
      ch_d    = '0;
      wrk_d   = '0;
    end else begin
      unique case (state_q)
        SYNC: begin
          if (ws_fall) state_d = SKIP;
        end

        // The rise after the ws fall carries the last bit of the previous frame.
        SKIP: begin
          if (sclk_rise) begin
            bit_d   = '0;
            ch_d    = '0;
            state_d = CAPT;
          end
        end

        CAPT: begin
          if (sclk_rise) begin
            if (32'(bit_q) < SAMPLE_W) begin
              wrk_d[ch_q] = {wrk_q[ch_q][SAMPLE_W-2:0], data_s};
            end

            if (ws_s != i2s_exp_ws(pos, FrameLen)) begin
              err_d   = 1'b1;
              state_d = SYNC;
              bit_d   = '0;
              ch_d    = '0;
              wrk_d   = '0;
            end else if (pos == FrameLen - 1) begin
              // Copy from wrk_d so a final sample bit on the last clock is included.
              smpl_d  = wrk_d;
              vld_d   = 1'b1;
              bit_d   = '0;
              ch_d    = '0;
            end else if (32'(bit_q) == SLOT_W - 1) begin
              bit_d   = '0;
              ch_d    = ch_q + ChW'(1);
            end else begin
              bit_d   = bit_q + BitW'(1);
            end
          end
        end

        default: state_d = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SYNC;
      bit_q   <= '0;
      ch_q    <= '0;
      wrk_q   <= '0;
      smpl_q  <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      ch_q    <= ch_d;
      wrk_q   <= wrk_d;
      smpl_q  <= smpl_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  assign smpl_out = smpl_q;
  assign vld      = vld_q;
  assign frm_err  = err_q;

endmodule

// File: tb/tb_i2s_rx_tdm.sv
// Bench for i2s_rx_tdm: a 24/32/2 instance and a 16/16/8 instance share one serial line.
// Frames are generated bit by bit from sample arrays; the expected parallel word for each
// frame is built directly from the samples, and the scenario decides which frames must
// produce vld.
module tb_i2s_rx_tdm;

  localparam int unsigned A_SW = 24, A_SL = 32, A_CH = 2;
  localparam int unsigned B_SW = 16, B_SL = 16, B_CH = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  logic sclk = 1'b0, ws = 1'b0, sdata = 1'b0;
  logic en_a = 1'b0, en_b = 1'b0;
  logic [A_CH*A_SW-1:0] smpl_a;
  logic [B_CH*B_SW-1:0] smpl_b;
  logic vld_a, err_a, vld_b, err_b;

  always #5 clk = ~clk;

  i2s_rx_tdm #(.SAMPLE_W(A_SW), .SLOT_W(A_SL), .NUM_CH(A_CH)) u_dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .I2S_sclk (sclk),
    .I2S_ws   (ws),
    .I2S_data (sdata),
    .en       (en_a),
    .smpl_out (smpl_a),
    .vld      (vld_a),
    .frm_err  (err_a)
  );

  i2s_rx_tdm #(.SAMPLE_W(B_SW), .SLOT_W(B_SL), .NUM_CH(B_CH)) u_dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .I2S_sclk (sclk),
    .I2S_ws   (ws),
    .I2S_data (sdata),
    .en       (en_b),
    .smpl_out (smpl_b),
    .vld      (vld_b),
    .frm_err  (err_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- output monitor
  logic [127:0] got_a[$], got_b[$], exp_a[$], exp_b[$];
  int   err_cnt_a = 0, err_cnt_b = 0;
  logic vld_prev_a = 1'b0, vld_prev_b = 1'b0;

  always @(negedge clk) begin
    if (vld_a || err_a) check("a_vld_err_exclusive", {127'b0, vld_a & err_a}, '0);
    if (vld_a) begin
      check("a_vld_single_cycle", {127'b0, vld_prev_a}, '0);
      got_a.push_back(128'(smpl_a));
    end
    if (err_a) err_cnt_a <= err_cnt_a + 1;
    vld_prev_a <= vld_a;

    if (vld_b || err_b) check("b_vld_err_exclusive", {127'b0, vld_b & err_b}, '0);
    if (vld_b) begin
      check("b_vld_single_cycle", {127'b0, vld_prev_b}, '0);
      got_b.push_back(128'(smpl_b));
    end
    if (err_b) err_cnt_b <= err_cnt_b + 1;
    vld_prev_b <= vld_b;
  end

  // ---------------------------------------------------------------- serial stimulus
  // One bit per call; data and ws change while sclk is low, 8 clk before the rise.
  task automatic send_bit(input logic b, input logic w);
    sdata = b;
    ws    = w;
    #80 sclk = 1'b1;
    #80 sclk = 1'b0;
  endtask

  // ws for each bit names the frame half that the following bit belongs to. A nonzero
  // 'early' drops ws that many bits before its normal fall at the end of the frame.
  task automatic send_frame(input int unsigned slot_w, input int unsigned sample_w,
                            input int unsigned nch, input logic [31:0] smp [8],
                            input int unsigned early);
    int unsigned f;
    f = nch * slot_w;
    for (int unsigned p = 0; p < f; p++) begin
      int unsigned c, i, next_ch;
      logic b, w;
      c = p / slot_w;
      i = p % slot_w;
      if (i < sample_w) b = smp[c][sample_w-1-i];
      else              b = 1'($urandom_range(0, 1));
      next_ch = ((p + 1) % f) / slot_w;
      w = (next_ch >= nch / 2);
      if (early != 0 && p + 1 + early >= f && p + 1 < f) w = 1'b0;
      send_bit(b, w);
    end
  endtask

  // A high bit then the low "previous LSB" bit: gives the ws fall that opens a frame.
  task automatic preamble();
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
  endtask

  function automatic logic [127:0] pack(input logic [31:0] smp [8], input int unsigned sw,
                                        input int unsigned nch);
    logic [127:0] v;
    v = '0;
    for (int unsigned c = 0; c < nch; c++)
      for (int unsigned i = 0; i < sw; i++) v[c*sw+i] = smp[c][i];
    return v;
  endfunction

  task automatic rand_smp(output logic [31:0] smp [8]);
    for (int c = 0; c < 8; c++) smp[c] = $urandom();
  endtask

  task automatic compare(input string tag, input bit is_b);
    if (!is_b) begin
      check({tag, "_vld_count"}, 128'(got_a.size()), 128'(exp_a.size()));
      foreach (exp_a[i]) if (i < got_a.size()) check({tag, "_frame"}, got_a[i], exp_a[i]);
      got_a.delete();
      exp_a.delete();
    end else begin
      check({tag, "_vld_count"}, 128'(got_b.size()), 128'(exp_b.size()));
      foreach (exp_b[i]) if (i < got_b.size()) check({tag, "_frame"}, got_b[i], exp_b[i]);
      got_b.delete();
      exp_b.delete();
    end
  endtask

  // ---------------------------------------------------------------- scenarios
  initial begin
    logic [31:0]  smp [8];
    logic [31:0]  smp2 [8];
    logic [127:0] last_a;

    #20;
    check("reset_smpl_a", 128'(smpl_a), '0);
    check("reset_vld_a", {127'b0, vld_a}, '0);
    check("reset_err_a", {127'b0, err_a}, '0);
    check("reset_smpl_b", 128'(smpl_b), '0);
    rst_n = 1'b1;
    en_a  = 1'b1;
    #100;

    // Fixed pattern, two frames
    smp = '{default: 32'h0};
    smp[0] = 32'hA5A5A5;
    smp[1] = 32'h5A5A5A;
    preamble();
    for (int k = 0; k < 2; k++) begin
      exp_a.push_back(pack(smp, A_SW, A_CH));
      send_frame(A_SL, A_SW, A_CH, smp, 0);
    end
    #100;
    compare("fixed", 1'b0);
    check("fixed_smpl", 128'(smpl_a), 128'({24'h5A5A5A, 24'hA5A5A5}));
    check("fixed_err_count", 128'(err_cnt_a), 128'(0));

    // Back-to-back: incrementing then random
    for (int k = 0; k < 5; k++) begin
      if (k < 2) begin
        smp = '{default: 32'h0};
        smp[0] = 32'(2 * k + 1);
        smp[1] = 32'(2 * k + 2);
      end else begin
        rand_smp(smp);
      end
      exp_a.push_back(pack(smp, A_SW, A_CH));
      send_frame(A_SL, A_SW, A_CH, smp, 0);
    end
    #100;
    compare("b2b", 1'b0);
    check("b2b_err_count", 128'(err_cnt_a), 128'(0));

    // Early ws fall in R slot: error frame and the next one lost, third one good
    rand_smp(smp);
    send_frame(A_SL, A_SW, A_CH, smp, 3);
    rand_smp(smp);
    send_frame(A_SL, A_SW, A_CH, smp, 0);
    rand_smp(smp);
    last_a = pack(smp, A_SW, A_CH);
    exp_a.push_back(last_a);
    send_frame(A_SL, A_SW, A_CH, smp, 0);
    #100;
    compare("ws_err", 1'b0);
    check("ws_err_count", 128'(err_cnt_a), 128'(1));

    // Enable dropped mid-frame: output holds, that frame lost, next frame good
    rand_smp(smp);
    rand_smp(smp2);
    fork
      begin
        send_frame(A_SL, A_SW, A_CH, smp, 0);
        exp_a.push_back(pack(smp2, A_SW, A_CH));
        send_frame(A_SL, A_SW, A_CH, smp2, 0);
      end
      begin
        #2500 en_a = 1'b0;
        #500;
        check("en_low_hold", 128'(smpl_a), last_a);
        #2000;
        check("en_low_hold_late", 128'(smpl_a), last_a);
        en_a = 1'b1;
      end
    join
    #100;
    compare("en_toggle", 1'b0);
    check("en_err_count", 128'(err_cnt_a), 128'(1));

    // Reset mid-frame: outputs clear at once, that frame lost, next frame good
    rand_smp(smp);
    rand_smp(smp2);
    fork
      begin
        send_frame(A_SL, A_SW, A_CH, smp, 0);
        exp_a.push_back(pack(smp2, A_SW, A_CH));
        send_frame(A_SL, A_SW, A_CH, smp2, 0);
      end
      begin
        #3003 rst_n = 1'b0;
        #1;
        check("rst_mid_smpl", 128'(smpl_a), '0);
        check("rst_mid_vld", {127'b0, vld_a}, '0);
        check("rst_mid_err", {127'b0, err_a}, '0);
        #2000 rst_n = 1'b1;
      end
    join
    #100;
    compare("rst_mid", 1'b0);
    check("rst_err_count", 128'(err_cnt_a), 128'(1));

    // Eight-channel instance, sample width equal to slot width
    en_a = 1'b0;
    en_b = 1'b1;
    #100;
    preamble();
    for (int k = 0; k < 3; k++) begin
      if (k == 0) begin
        for (int c = 0; c < 8; c++) smp[c] = 32'h1110 + 32'(c);
      end else begin
        rand_smp(smp);
      end
      exp_b.push_back(pack(smp, B_SW, B_CH));
      send_frame(B_SL, B_SW, B_CH, smp, 0);
    end
    #100;
    compare("tdm8", 1'b0 | 1'b1);
    check("tdm8_err_count", 128'(err_cnt_b), 128'(0));
    check("tdm8_a_quiet", 128'(err_cnt_a), 128'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
